// File: rtl/delta_trend_detector.sv
// Sample-to-sample trend detector: flags rising/falling moves and stable runs.
// Optional signed diff output enabled by defining DELTA_TREND_MAG_EN.
module delta_trend_detector #(
    parameter int WIDTH      = 3,
    parameter int DELTA_MIN  = 1,
    parameter int STABLE_LEN = 2,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic [WIDTH-1:0]        status,
    output logic                    upd,
    output logic                    rising,
    output logic                    falling,
    output logic                    stable,
    output logic [CNT_W-1:0]        run
`ifdef DELTA_TREND_MAG_EN
    ,
    output logic signed [WIDTH:0]   delta
`endif
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        TRACK  = 2'd2
    } state_t;

    localparam logic signed [WIDTH:0] DMIN    = (WIDTH+1)'(DELTA_MIN);
    localparam logic [CNT_W-1:0]      STB     = CNT_W'(STABLE_LEN);
    localparam logic [CNT_W-1:0]      RUN_MAX = '1;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               upd_q, upd_d;
    logic               rising_q, rising_d;
    logic               falling_q, falling_d;
    logic               stable_q, stable_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic signed [WIDTH:0] diff;
    logic               near;
`ifdef DELTA_TREND_MAG_EN
    logic signed [WIDTH:0] delta_q, delta_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = EMPTY;
        else if (sample_en)
            state_d = (state_q == EMPTY) ? PRIMED : TRACK;
    end

    // Zero-extend both operands so the difference never wraps.
    always_comb begin
        diff      = $signed({1'b0, status}) - $signed({1'b0, prev_q});
        near      = (diff < DMIN) && (diff > -DMIN);
        prev_d    = prev_q;
        upd_d     = 1'b0;
        rising_d  = rising_q;
        falling_d = falling_q;
        stable_d  = stable_q;
        run_d     = run_q;
`ifdef DELTA_TREND_MAG_EN
        delta_d   = delta_q;
`endif
        if (clear) begin
            prev_d    = '0;
            rising_d  = 1'b0;
            falling_d = 1'b0;
            stable_d  = 1'b0;
            run_d     = '0;
`ifdef DELTA_TREND_MAG_EN
            delta_d   = '0;
`endif
        end else if (sample_en) begin
            prev_d = status;
            if (state_q != EMPTY) begin
                upd_d     = 1'b1;
                rising_d  = (diff >= DMIN);
                falling_d = (diff <= -DMIN);
                if (!near)
                    run_d = '0;
                else if (run_q != RUN_MAX)
                    run_d = run_q + CNT_W'(1);
                stable_d  = (run_d >= STB);
`ifdef DELTA_TREND_MAG_EN
                delta_d   = diff;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            upd_q     <= 1'b0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
            stable_q  <= 1'b0;
            run_q     <= '0;
`ifdef DELTA_TREND_MAG_EN
            delta_q   <= '0;
`endif
        end else begin
            prev_q    <= prev_d;
            upd_q     <= upd_d;
            rising_q  <= rising_d;
            falling_q <= falling_d;
            stable_q  <= stable_d;
            run_q     <= run_d;
`ifdef DELTA_TREND_MAG_EN
            delta_q   <= delta_d;
`endif
        end
    end

    assign upd     = upd_q;
    assign rising  = rising_q;
    assign falling = falling_q;
    assign stable  = stable_q;
    assign run     = run_q;
`ifdef DELTA_TREND_MAG_EN
    assign delta   = delta_q;
`endif

endmodule

// File: tb/tb_delta_trend_detector.sv
// Scoreboard bench for delta_trend_detector over three parameter sets.
module tb_delta_trend_detector;

    typedef struct {
        bit r;
        bit f;
        bit s;
        int rn;
        int d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [2:0] st0 = '0, st1 = '0, st2 = '0;
    logic upd0, ri0, fa0, sb0;
    logic upd1, ri1, fa1, sb1;
    logic upd2, ri2, fa2, sb2;
    logic [7:0] run0, run1;
    logic [1:0] run2;
`ifdef DELTA_TREND_MAG_EN
    logic signed [3:0] dl0, dl1, dl2;
`endif

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    delta_trend_detector u0 (
        .clk(clk), .reset(rst), .clear(clr0), .sample_en(en0),
        .status(st0), .upd(upd0), .rising(ri0), .falling(fa0),
        .stable(sb0), .run(run0)
`ifdef DELTA_TREND_MAG_EN
        , .delta(dl0)
`endif
    );

    delta_trend_detector #(.DELTA_MIN(2)) u1 (
        .clk(clk), .reset(rst), .clear(clr1), .sample_en(en1),
        .status(st1), .upd(upd1), .rising(ri1), .falling(fa1),
        .stable(sb1), .run(run1)
`ifdef DELTA_TREND_MAG_EN
        , .delta(dl1)
`endif
    );

    delta_trend_detector #(.CNT_W(2), .STABLE_LEN(3)) u2 (
        .clk(clk), .reset(rst), .clear(clr2), .sample_en(en2),
        .status(st2), .upd(upd2), .rising(ri2), .falling(fa2),
        .stable(sb2), .run(run2)
`ifdef DELTA_TREND_MAG_EN
        , .delta(dl2)
`endif
    );

    function automatic void chk(string name, int act, int req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic void cmp(string id, exp_t e, bit r, bit f,
                                bit s, int rn, int d);
        chk({id, " rising"}, int'(r), int'(e.r));
        chk({id, " falling"}, int'(f), int'(e.f));
        chk({id, " stable"}, int'(s), int'(e.s));
        chk({id, " run"}, rn, e.rn);
`ifdef DELTA_TREND_MAG_EN
        chk({id, " delta"}, d, e.d);
`else
        if (d != 0) $display("note: unexpected delta arg %0d", d);
`endif
    endfunction

    // Monitors: pop one expectation per upd pulse.
    always @(negedge clk) begin
        if (upd0) begin
            if (q0.size() == 0) chk("dut0 spurious upd", int'(upd0), 0);
            else begin
                e0 = q0.pop_front();
`ifdef DELTA_TREND_MAG_EN
                cmp("dut0", e0, ri0, fa0, sb0, int'(run0), int'(dl0));
`else
                cmp("dut0", e0, ri0, fa0, sb0, int'(run0), 0);
`endif
            end
        end
        if (upd1) begin
            if (q1.size() == 0) chk("dut1 spurious upd", int'(upd1), 0);
            else begin
                e1 = q1.pop_front();
`ifdef DELTA_TREND_MAG_EN
                cmp("dut1", e1, ri1, fa1, sb1, int'(run1), int'(dl1));
`else
                cmp("dut1", e1, ri1, fa1, sb1, int'(run1), 0);
`endif
            end
        end
        if (upd2) begin
            if (q2.size() == 0) chk("dut2 spurious upd", int'(upd2), 0);
            else begin
                e2 = q2.pop_front();
`ifdef DELTA_TREND_MAG_EN
                cmp("dut2", e2, ri2, fa2, sb2, int'(run2), int'(dl2));
`else
                cmp("dut2", e2, ri2, fa2, sb2, int'(run2), 0);
`endif
            end
        end
    end

    task automatic smp(input int id, input int v, input bit u,
                       input bit r = 0, input bit f = 0, input bit s = 0,
                       input int rn = 0, input int d = 0);
        exp_t e;
        e = '{r, f, s, rn, d};
        case (id)
            0: begin
                if (u) q0.push_back(e);
                en0 = 1'b1; st0 = 3'(v);
            end
            1: begin
                if (u) q1.push_back(e);
                en1 = 1'b1; st1 = 3'(v);
            end
            default: begin
                if (u) q2.push_back(e);
                en2 = 1'b1; st2 = 3'(v);
            end
        endcase
        @(posedge clk);
        #1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset upd", int'(upd0), 0);
        chk("reset flags", int'({ri0, fa0, sb0}), 0);
        chk("reset run", int'(run0), 0);
        chk("reset run2", int'(run2), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // defaults: priming, rising, stability, falling
        smp(0, 3, 0);
        smp(0, 5, 1, 1, 0, 0, 0, 2);
        smp(0, 5, 1, 0, 0, 0, 1, 0);
        smp(0, 5, 1, 0, 0, 1, 2, 0);
        smp(0, 5, 1, 0, 0, 1, 3, 0);
        smp(0, 4, 1, 0, 1, 0, 0, -1);
        // extremes without wrap
        smp(0, 7, 1, 1, 0, 0, 0, 3);
        smp(0, 0, 1, 0, 1, 0, 0, -7);
        smp(0, 7, 1, 1, 0, 0, 0, 7);
        smp(0, 7, 1, 0, 0, 0, 1, 0);
        smp(0, 7, 1, 0, 0, 1, 2, 0);
        // clear colliding with a sample
        clr0 = 1'b1;
        smp(0, 6, 0);
        clr0 = 1'b0;
        @(negedge clk);
        chk("clear upd", int'(upd0), 0);
        chk("clear flags", int'({ri0, fa0, sb0}), 0);
        chk("clear run", int'(run0), 0);
        @(posedge clk);
        #1;
        smp(0, 6, 0);
        smp(0, 6, 1, 0, 0, 0, 1, 0);

        // DELTA_MIN = 2 tolerance
        smp(1, 4, 0);
        smp(1, 5, 1, 0, 0, 0, 1, 1);
        smp(1, 3, 1, 0, 1, 0, 0, -2);
        smp(1, 6, 1, 1, 0, 0, 0, 3);
        smp(1, 7, 1, 0, 0, 0, 1, 1);
        smp(1, 7, 1, 0, 0, 1, 2, 0);

        // CNT_W = 2 saturation, STABLE_LEN = 3
        smp(2, 4, 0);
        smp(2, 4, 1, 0, 0, 0, 1, 0);
        smp(2, 4, 1, 0, 0, 0, 2, 0);
        smp(2, 4, 1, 0, 0, 1, 3, 0);
        smp(2, 4, 1, 0, 0, 1, 3, 0);
        smp(2, 4, 1, 0, 0, 1, 3, 0);
        smp(2, 4, 1, 0, 0, 1, 3, 0);
        smp(2, 1, 1, 0, 1, 0, 0, -3);

        repeat (3) @(posedge clk);
        chk("dut0 pending", q0.size(), 0);
        chk("dut1 pending", q1.size(), 0);
        chk("dut2 pending", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
